// File: rtl/mips_pipe_pkg.sv
// Purpose : Shared constants and types for the IF/ID boundary.
//           MIPS instruction field positions, the NOP encoding, and the decoded-field bundle
//           together with a helper that slices an instruction into that bundle.
// Ports   : none (package).
package mips_pipe_pkg;

  localparam int unsigned MIPS_INST_W = 32;

  // Field positions within a 32-bit MIPS instruction
  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;
  localparam int unsigned JADR_HI  = 25;
  localparam int unsigned JADR_LO  = 0;
  // FP (COP1) view reuses the integer positions
  localparam int unsigned FMT_HI   = RS_HI;
  localparam int unsigned FMT_LO   = RS_LO;
  localparam int unsigned FS_HI    = RD_HI;
  localparam int unsigned FS_LO    = RD_LO;
  localparam int unsigned FD_HI    = SHAMT_HI;
  localparam int unsigned FD_LO    = SHAMT_LO;

  // sll $0,$0,0
  localparam logic [MIPS_INST_W-1:0] NOP_INST = 32'h0000_0000;

  // Decoded-field widths
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JADR_W  = 26;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [JADR_W-1:0]  jadr;
    logic [REG_W-1:0]   fmt;
    logic [REG_W-1:0]   fs;
    logic [REG_W-1:0]   fd;
  } id_fields_t;

  function automatic id_fields_t decode_inst(input logic [MIPS_INST_W-1:0] inst);
    id_fields_t d;
    d.op    = inst[OP_HI:OP_LO];
    d.rs    = inst[RS_HI:RS_LO];
    d.rt    = inst[RT_HI:RT_LO];
    d.rd    = inst[RD_HI:RD_LO];
    d.shamt = inst[SHAMT_HI:SHAMT_LO];
    d.funct = inst[FUNCT_HI:FUNCT_LO];
    d.imm   = inst[IMM_HI:IMM_LO];
    d.jadr  = inst[JADR_HI:JADR_LO];
    d.fmt   = inst[FMT_HI:FMT_LO];
    d.fs    = inst[FS_HI:FS_LO];
    d.fd    = inst[FD_HI:FD_LO];
    return d;
  endfunction

endpackage

// File: rtl/pipe_fifo_core.sv
// Purpose : DEPTH-entry elastic FIFO with valid/ready on both sides and a synchronous flush.
//           Storage is not reset; pointers and occupancy are.
// Ports   : Clk, Rst_n (async, active-low), In_valid/In_ready/In_data (write side),
//           Flush, Out_valid/Out_ready/Out_data (read side, head entry), Count (occupancy).
module pipe_fifo_core #(
  parameter int unsigned W      = 64,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [W-1:0]      In_data,
  input  logic              Flush,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [W-1:0]      Out_data,
  output logic [ADDR_W:0]   Count
);

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

  logic [W-1:0]      r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  // Ready depends on registered occupancy only, so a full buffer refuses a push
  // even in a cycle where the head is being popped.
  assign In_ready  = (r_count != FullCnt);
  assign Out_valid = (r_count != '0);
  assign Out_data  = r_mem[r_rd_ptr];
  assign Count     = r_count;

  assign w_push = In_valid & In_ready & ~Flush;
  assign w_pop  = Out_valid & Out_ready & ~Flush;

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= In_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap on plain overflow
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_pipe_buf.sv
// Purpose : IF/ID boundary buffer. Holds instruction + PC+4 pairs from fetch in an elastic
//           FIFO and presents the head decoded into MIPS integer/FP fields for decode.
//           With the buffer empty every field output and PC_ID read as zero (a NOP).
//           Field slicing assumes INST_W = 32.
// Ports   : Clk, Rst_n (async, active-low); fetch side In_valid/In_ready/Inst/PC_4; Flush;
//           decode side Out_valid/Out_ready and decoded fields Op_code..Fd, PC_ID; Count.
module if_id_pipe_buf
  import mips_pipe_pkg::*;
#(
  parameter int unsigned INST_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                In_valid,
  output logic                In_ready,
  input  logic [INST_W-1:0]   Inst,
  input  logic [PC_W-1:0]     PC_4,
  input  logic                Flush,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic [OP_W-1:0]     Op_code,
  output logic [REG_W-1:0]    Rs_ID,
  output logic [REG_W-1:0]    Rt_ID,
  output logic [REG_W-1:0]    Rd_ID,
  output logic [REG_W-1:0]    Shamt_ID,
  output logic [FUNCT_W-1:0]  Funct_ID,
  output logic [IMM_W-1:0]    Imm16_ID,
  output logic [JADR_W-1:0]   Jmp_Adrs_ID,
  output logic [REG_W-1:0]    Fmt,
  output logic [REG_W-1:0]    Fs,
  output logic [REG_W-1:0]    Fd,
  output logic [PC_W-1:0]     PC_ID,
  output logic [ADDR_W:0]     Count
);

  localparam int unsigned DataW = INST_W + PC_W;

  logic [DataW-1:0]  w_head;
  logic              w_out_valid;
  logic [INST_W-1:0] w_inst;
  id_fields_t        w_fields;

  pipe_fifo_core #(
    .W     (DataW),
    .DEPTH (DEPTH)
  ) u_core (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_data   ({Inst, PC_4}),
    .Flush     (Flush),
    .Out_valid (w_out_valid),
    .Out_ready (Out_ready),
    .Out_data  (w_head),
    .Count     (Count)
  );

  assign Out_valid = w_out_valid;

  // Empty buffer presents a NOP so ID never decodes stale storage
  always_comb begin
    w_inst   = w_out_valid ? w_head[DataW-1:PC_W] : NOP_INST;
    w_fields = decode_inst(w_inst);
    PC_ID    = w_out_valid ? w_head[PC_W-1:0] : '0;
  end

  assign Op_code     = w_fields.op;
  assign Rs_ID       = w_fields.rs;
  assign Rt_ID       = w_fields.rt;
  assign Rd_ID       = w_fields.rd;
  assign Shamt_ID    = w_fields.shamt;
  assign Funct_ID    = w_fields.funct;
  assign Imm16_ID    = w_fields.imm;
  assign Jmp_Adrs_ID = w_fields.jadr;
  assign Fmt         = w_fields.fmt;
  assign Fs          = w_fields.fs;
  assign Fd          = w_fields.fd;

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Self-checking bench: instance a (DEPTH=2) and instance b (DEPTH=4) share clock and reset.
// A queue model per instance predicts occupancy/handshake/fields every falling edge.
module tb_if_id_pipe_buf;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance a: DEPTH = 2
  logic a_in_valid = 0, a_flush = 0, a_out_ready = 0;
  logic [31:0] a_inst = 0, a_pc = 0;
  logic a_in_ready, a_out_valid;
  logic [5:0] a_op, a_fn;
  logic [4:0] a_rs, a_rt, a_rd, a_sh, a_fmt, a_fs, a_fd;
  logic [15:0] a_imm;
  logic [25:0] a_jmp;
  logic [31:0] a_pc_id;
  logic [1:0] a_count;

  // Instance b: DEPTH = 4
  logic b_in_valid = 0, b_flush = 0, b_out_ready = 0;
  logic [31:0] b_inst = 0, b_pc = 0;
  logic b_in_ready, b_out_valid;
  logic [5:0] b_op, b_fn;
  logic [4:0] b_rs, b_rt, b_rd, b_sh, b_fmt, b_fs, b_fd;
  logic [15:0] b_imm;
  logic [25:0] b_jmp;
  logic [31:0] b_pc_id;
  logic [2:0] b_count;

  if_id_pipe_buf #(.INST_W(32), .PC_W(32), .DEPTH(2)) u_a (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(a_in_valid), .In_ready(a_in_ready), .Inst(a_inst),
    .PC_4(a_pc), .Flush(a_flush), .Out_valid(a_out_valid), .Out_ready(a_out_ready),
    .Op_code(a_op), .Rs_ID(a_rs), .Rt_ID(a_rt), .Rd_ID(a_rd), .Shamt_ID(a_sh),
    .Funct_ID(a_fn), .Imm16_ID(a_imm), .Jmp_Adrs_ID(a_jmp), .Fmt(a_fmt), .Fs(a_fs),
    .Fd(a_fd), .PC_ID(a_pc_id), .Count(a_count)
  );

  if_id_pipe_buf #(.INST_W(32), .PC_W(32), .DEPTH(4)) u_b (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(b_in_valid), .In_ready(b_in_ready), .Inst(b_inst),
    .PC_4(b_pc), .Flush(b_flush), .Out_valid(b_out_valid), .Out_ready(b_out_ready),
    .Op_code(b_op), .Rs_ID(b_rs), .Rt_ID(b_rt), .Rd_ID(b_rd), .Shamt_ID(b_sh),
    .Funct_ID(b_fn), .Imm16_ID(b_imm), .Jmp_Adrs_ID(b_jmp), .Fmt(b_fmt), .Fs(b_fs),
    .Fd(b_fd), .PC_ID(b_pc_id), .Count(b_count)
  );

  wire [120:0] a_fields = {a_op, a_rs, a_rt, a_rd, a_sh, a_fn, a_imm, a_jmp, a_fmt, a_fs, a_fd,
                           a_pc_id};
  wire [120:0] b_fields = {b_op, b_rs, b_rt, b_rd, b_sh, b_fn, b_imm, b_jmp, b_fmt, b_fs, b_fd,
                           b_pc_id};

  // Expected field bundle straight from the MIPS bit positions
  function automatic logic [120:0] exp_fields(input logic [63:0] e);
    logic [31:0] i;
    logic [31:0] p;
    i = e[63:32];
    p = e[31:0];
    return {i[31:26], i[25:21], i[20:16], i[15:11], i[10:6], i[5:0], i[15:0], i[25:0],
            i[25:21], i[15:11], i[10:6], p};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: contents of each buffer as a queue of {inst, pc}
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [31:0] pop_a[$];
  logic [31:0] pop_b[$];
  int max_b = 0;

  always @(negedge Rst_n) begin
    qa.delete();
    qb.delete();
  end

  always @(posedge Clk) begin
    if (Rst_n) begin
      if (a_flush) qa.delete();
      else begin
        // Capacity is judged on pre-edge occupancy; a full buffer never takes a word
        automatic bit pa = a_in_valid && qa.size() < 2;
        if (a_out_ready && qa.size() > 0) void'(qa.pop_front());
        if (pa) qa.push_back({a_inst, a_pc});
      end
      if (b_flush) qb.delete();
      else begin
        automatic bit pb = b_in_valid && qb.size() < 4;
        if (b_out_ready && qb.size() > 0) void'(qb.pop_front());
        if (pb) qb.push_back({b_inst, b_pc});
      end
    end
  end

  // Compare process: outputs are settled half a cycle away from the active edge
  always @(negedge Clk) begin
    check("a.count", 128'(a_count), 128'(qa.size()));
    check("a.out_valid", 128'(a_out_valid), 128'(qa.size() != 0));
    check("a.in_ready", 128'(a_in_ready), 128'(qa.size() != 2));
    check("a.fields", 128'(a_fields), qa.size() != 0 ? 128'(exp_fields(qa[0])) : 128'(0));
    check("b.count", 128'(b_count), 128'(qb.size()));
    check("b.out_valid", 128'(b_out_valid), 128'(qb.size() != 0));
    check("b.in_ready", 128'(b_in_ready), 128'(qb.size() != 4));
    check("b.fields", 128'(b_fields), qb.size() != 0 ? 128'(exp_fields(qb[0])) : 128'(0));
    if (Rst_n && a_out_valid && a_out_ready && !a_flush) pop_a.push_back(a_pc_id);
    if (Rst_n && b_out_valid && b_out_ready && !b_flush) pop_b.push_back(b_pc_id);
    if (int'(b_count) > max_b) max_b = int'(b_count);
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int i;
    int guard;

    // 1. Reset then idle
    step(2);
    check("t1.rst_out_valid", 128'(a_out_valid), 128'(0));
    check("t1.rst_in_ready", 128'(a_in_ready), 128'(1));
    check("t1.rst_count", 128'(a_count), 128'(0));
    check("t1.rst_fields", 128'(a_fields), 128'(0));
    Rst_n = 1'b1;
    step(2);
    check("t1.idle_count", 128'(a_count), 128'(0));
    check("t1.idle_out_valid", 128'(a_out_valid), 128'(0));

    // 2. Single pass
    a_inst = 32'hFC1F_07C0; a_pc = 32'h4; a_in_valid = 1; a_out_ready = 1;
    step(1);
    a_in_valid = 0;
    check("t2.op", 128'(a_op), 128'(6'h3F));
    check("t2.rs", 128'(a_rs), 128'(0));
    check("t2.rt", 128'(a_rt), 128'(5'h1F));
    check("t2.rd", 128'(a_rd), 128'(0));
    check("t2.shamt", 128'(a_sh), 128'(5'h1F));
    check("t2.funct", 128'(a_fn), 128'(0));
    check("t2.imm", 128'(a_imm), 128'(16'h07C0));
    check("t2.jmp", 128'(a_jmp), 128'(26'h01F07C0));
    check("t2.fd", 128'(a_fd), 128'(5'h1F));
    check("t2.pc", 128'(a_pc_id), 128'(32'h4));
    step(1);
    check("t2.drained_count", 128'(a_count), 128'(0));

    // 3. Fill / back-pressure
    pop_a.delete();
    a_out_ready = 0;
    a_in_valid = 1; a_inst = 32'h0123_4567; a_pc = 32'h10;
    step(1);
    a_inst = 32'h89AB_CDEF; a_pc = 32'h20;
    step(1);
    a_inst = 32'h3C01_1234; a_pc = 32'h30;
    check("t3.full_in_ready", 128'(a_in_ready), 128'(0));
    check("t3.full_count", 128'(a_count), 128'(2));
    step(1);
    check("t3.held_count", 128'(a_count), 128'(2));
    a_out_ready = 1;
    step(1);
    check("t3.refused_count", 128'(a_count), 128'(1));
    step(1);
    a_in_valid = 0;
    step(2);
    check("t3.pop_n", 128'(pop_a.size()), 128'(3));
    if (pop_a.size() == 3) begin
      check("t3.order0", 128'(pop_a[0]), 128'(32'h10));
      check("t3.order1", 128'(pop_a[1]), 128'(32'h20));
      check("t3.order2", 128'(pop_a[2]), 128'(32'h30));
    end

    // 4. Flush mid-stream (full, then one entry with an acceptable push)
    pop_a.delete();
    a_out_ready = 0; a_in_valid = 1; a_inst = 32'h2108_0001; a_pc = 32'h40;
    step(1);
    a_inst = 32'h2108_0002; a_pc = 32'h50;
    step(1);
    check("t4.pre_count", 128'(a_count), 128'(2));
    a_flush = 1; a_out_ready = 1; a_inst = 32'hDEAD_BEEF; a_pc = 32'h99;
    step(1);
    a_flush = 0; a_in_valid = 0;
    check("t4.count", 128'(a_count), 128'(0));
    check("t4.out_valid", 128'(a_out_valid), 128'(0));
    check("t4.in_ready", 128'(a_in_ready), 128'(1));
    check("t4.fields", 128'(a_fields), 128'(0));
    a_out_ready = 0; a_in_valid = 1; a_inst = 32'h2108_0006; a_pc = 32'h60;
    step(1);
    a_flush = 1; a_inst = 32'hBAD0_BAD0; a_pc = 32'h98;
    step(1);
    a_flush = 0; a_in_valid = 0;
    check("t4b.count", 128'(a_count), 128'(0));
    a_in_valid = 1; a_out_ready = 1; a_inst = 32'h2108_0007; a_pc = 32'h70;
    step(1);
    a_in_valid = 0;
    step(2);
    check("t4.pop_n", 128'(pop_a.size()), 128'(1));
    if (pop_a.size() == 1) check("t4.pop0", 128'(pop_a[0]), 128'(32'h70));

    // 6. Async reset mid-operation
    a_out_ready = 0; a_in_valid = 1; a_inst = 32'h0000_0021; a_pc = 32'h80;
    step(1);
    a_inst = 32'h0000_0022; a_pc = 32'h90;
    step(1);
    a_in_valid = 0;
    check("t6.pre_count", 128'(a_count), 128'(2));
    #2 Rst_n = 1'b0;
    #1;
    check("t6.async_out_valid", 128'(a_out_valid), 128'(0));
    check("t6.async_count", 128'(a_count), 128'(0));
    check("t6.async_in_ready", 128'(a_in_ready), 128'(1));
    step(1);
    Rst_n = 1'b1;
    a_in_valid = 1; a_out_ready = 1; a_inst = 32'h0000_0023; a_pc = 32'hA0;
    step(1);
    a_in_valid = 0;
    check("t6.post_count", 128'(a_count), 128'(1));
    check("t6.post_pc", 128'(a_pc_id), 128'(32'hA0));
    step(1);

    // 5. Wrap-around on DEPTH=4 with pseudo-random stalls
    pop_b.delete();
    max_b = 0;
    i = 0;
    guard = 0;
    while (i < 10 && guard < 400) begin
      b_in_valid = 1;
      b_inst = 32'h1234_0000 ^ (32'h0101_0101 * i);
      b_pc = 32'h100 + 32'(4 * i);
      b_out_ready = ($urandom_range(0, 3) == 0);
      @(negedge Clk);
      acc = b_in_ready;
      step(1);
      if (acc) i++;
      guard++;
    end
    check("t5.all_pushed", 128'(i), 128'(10));
    b_in_valid = 0;
    b_out_ready = 1;
    guard = 0;
    while (b_count != 0 && guard < 20) begin
      step(1);
      guard++;
    end
    check("t5.drained", 128'(b_count), 128'(0));
    check("t5.max_count_le4", 128'(max_b <= 4), 128'(1));
    check("t5.pop_n", 128'(pop_b.size()), 128'(10));
    for (int k = 0; k < 10 && k < pop_b.size(); k++) begin
      check("t5.order", 128'(pop_b[k]), 128'(32'h100 + 32'(4 * k)));
    end
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
